// File: rtl/debounce_sync.sv
// debounce_sync: synchroniser chain followed by a 4-state stability FSM.
// A raw asynchronous level is committed to Q_OUT only after the synchronised
// sample has held the new level for DB_CYCLES consecutive clocks.
// Optional build macro: DEBOUNCE_PULSE_EN enables a registered one-cycle
// strobe on PULSE for every 0->1 commit; without it PULSE is tied to 0.
module debounce_sync #(
    parameter int SYNC_STAGES = 2,
    parameter int DB_CYCLES   = 4,
    parameter int CNT_W       = 8
) (
    input  logic CLK,
    input  logic RESET,
    input  logic D_IN,
    output logic Q_OUT,
    output logic BUSY,
    output logic PULSE
);

    localparam logic [1:0] IDLE_LO = 2'd0;
    localparam logic [1:0] CHK_HI  = 2'd1;
    localparam logic [1:0] IDLE_HI = 2'd2;
    localparam logic [1:0] CHK_LO  = 2'd3;

    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DB_CYCLES - 1);
    localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);

    logic [SYNC_STAGES-1:0] sync_q;
    logic                   s;
    logic [1:0]             state;
    logic [1:0]             state_d;
    logic [CNT_W-1:0]       cnt;
    logic [CNT_W-1:0]       cnt_d;
    logic                   q_d;

    // Shift the raw input through the synchroniser; only the last stage is used
    always_ff @(posedge CLK or posedge RESET) begin
        if (RESET) begin
            sync_q <= '0;
        end else begin
            sync_q <= {sync_q[SYNC_STAGES-2:0], D_IN};
        end
    end

    assign s = sync_q[SYNC_STAGES-1];

    // Next-state logic: count consecutive samples at the new level, abort on any reversal
    always_comb begin
        state_d = state;
        cnt_d   = cnt;
        q_d     = Q_OUT;
        case (state)
            IDLE_LO: begin
                if (s) begin
                    state_d = CHK_HI;
                    cnt_d   = CNT_ONE;
                end
            end
            CHK_HI: begin
                if (!s) begin
                    state_d = IDLE_LO;
                    cnt_d   = '0;
                end else if (cnt == CNT_LAST) begin
                    state_d = IDLE_HI;
                    cnt_d   = '0;
                    q_d     = 1'b1;
                end else begin
                    cnt_d   = cnt + CNT_ONE;
                end
            end
            IDLE_HI: begin
                if (!s) begin
                    state_d = CHK_LO;
                    cnt_d   = CNT_ONE;
                end
            end
            default: begin
                if (s) begin
                    state_d = IDLE_HI;
                    cnt_d   = '0;
                end else if (cnt == CNT_LAST) begin
                    state_d = IDLE_LO;
                    cnt_d   = '0;
                    q_d     = 1'b0;
                end else begin
                    cnt_d   = cnt + CNT_ONE;
                end
            end
        endcase
    end

    // State, counter and debounced output registers; reset drops any partial count
    always_ff @(posedge CLK or posedge RESET) begin
        if (RESET) begin
            state <= IDLE_LO;
            cnt   <= '0;
            Q_OUT <= 1'b0;
        end else begin
            state <= state_d;
            cnt   <= cnt_d;
            Q_OUT <= q_d;
        end
    end

    assign BUSY = (state == CHK_HI) | (state == CHK_LO);

`ifdef DEBOUNCE_PULSE_EN
    logic rise_commit;
    logic pulse_q;

    assign rise_commit = (state == CHK_HI) && s && (cnt == CNT_LAST);

    // Strobe registered alongside Q_OUT so it is high exactly in the cycle Q_OUT first reads 1
    always_ff @(posedge CLK or posedge RESET) begin
        if (RESET) begin
            pulse_q <= 1'b0;
        end else begin
            pulse_q <= rise_commit;
        end
    end

    assign PULSE = pulse_q;
`else
    assign PULSE = 1'b0;
`endif

endmodule

// File: tb/tb_debounce_sync.sv
// tb_debounce_sync: directed table vectors plus hand-written multi-cycle
// sequences for the default debounce_sync and a SYNC_STAGES=3/DB_CYCLES=10 copy.
module tb_debounce_sync;

`ifdef DEBOUNCE_PULSE_EN
    localparam logic PEN = 1'b1;
`else
    localparam logic PEN = 1'b0;
`endif

    logic CLK = 1'b0;
    logic RESET;
    logic d_a;
    logic d_b;
    logic q_a, busy_a, pulse_a;
    logic q_b, busy_b, pulse_b;

    int total = 0;
    int bad   = 0;

    typedef struct {
        logic rst;
        logic d;
        logic q;
        logic busy;
        logic rise;
    } vec_t;

    vec_t vecs[$];

    debounce_sync dut_a (
        .CLK   (CLK),
        .RESET (RESET),
        .D_IN  (d_a),
        .Q_OUT (q_a),
        .BUSY  (busy_a),
        .PULSE (pulse_a)
    );

    debounce_sync #(.SYNC_STAGES(3), .DB_CYCLES(10), .CNT_W(8)) dut_b (
        .CLK   (CLK),
        .RESET (RESET),
        .D_IN  (d_b),
        .Q_OUT (q_b),
        .BUSY  (busy_b),
        .PULSE (pulse_b)
    );

    // Free-running clock, posedges at 5, 15, 25, ...
    always #5 CLK = ~CLK;

    // Drive inputs on the falling edge, then return 1 time unit after the next rising edge
    task automatic applyStimulus(input logic rst, input logic da, input logic db);
        @(negedge CLK);
        RESET = rst;
        d_a   = da;
        d_b   = db;
        @(posedge CLK);
        #1;
    endtask

    // Compare one value and log a failure line when it differs
    task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("[TB] FAIL %s got=%0h want=%0h", name, act, exp);
        end
    endtask

    task automatic pushVec(input logic rst, input logic d, input logic q, input logic busy, input logic rise);
        vec_t v;
        v.rst  = rst;
        v.d    = d;
        v.q    = q;
        v.busy = busy;
        v.rise = rise;
        vecs.push_back(v);
    endtask

    // Main test sequence
    initial begin
        int  busyCount;
        logic qEver;
        logic pulseEver;
        int  riseEdge;
        logic pulseAtRise;

        // Reset held two edges, then idle
        pushVec(1, 0, 0, 0, 0);
        pushVec(1, 0, 0, 0, 0);
        pushVec(0, 0, 0, 0, 0);
        pushVec(0, 0, 0, 0, 0);
        // Clean rise: busy after edges 3..5, commit at edge 6
        pushVec(0, 1, 0, 0, 0);
        pushVec(0, 1, 0, 0, 0);
        pushVec(0, 1, 0, 1, 0);
        pushVec(0, 1, 0, 1, 0);
        pushVec(0, 1, 0, 1, 0);
        pushVec(0, 1, 1, 0, 1);
        pushVec(0, 1, 1, 0, 0);
        pushVec(0, 1, 1, 0, 0);
        // Clean fall: commit at edge 6, no strobe
        pushVec(0, 0, 1, 0, 0);
        pushVec(0, 0, 1, 0, 0);
        pushVec(0, 0, 1, 1, 0);
        pushVec(0, 0, 1, 1, 0);
        pushVec(0, 0, 1, 1, 0);
        pushVec(0, 0, 0, 0, 0);
        pushVec(0, 0, 0, 0, 0);
        pushVec(0, 0, 0, 0, 0);

        // Asynchronous reset with D_IN high, checked before any clock edge
        RESET = 1'b0;
        d_a   = 1'b1;
        d_b   = 1'b1;
        #2;
        RESET = 1'b1;
        #1;
        checkOutput("async_rst_q", q_a, 0);
        checkOutput("async_rst_busy", busy_a, 0);
        checkOutput("async_rst_pulse", pulse_a, 0);
        checkOutput("async_rst_q_b", q_b, 0);

        for (int i = 0; i < vecs.size(); i++) begin
            applyStimulus(vecs[i].rst, vecs[i].d, 1'b0);
            checkOutput($sformatf("vec%0d_q", i), q_a, vecs[i].q);
            checkOutput($sformatf("vec%0d_busy", i), busy_a, vecs[i].busy);
            checkOutput($sformatf("vec%0d_pulse", i), pulse_a, vecs[i].rise & PEN);
        end

        // Three-cycle glitch: busy for exactly three cycles, never commits
        busyCount = 0;
        qEver     = 1'b0;
        pulseEver = 1'b0;
        for (int k = 1; k <= 12; k++) begin
            applyStimulus(1'b0, (k <= 3), 1'b0);
            if (busy_a) busyCount++;
            qEver     = qEver | q_a;
            pulseEver = pulseEver | pulse_a;
        end
        checkOutput("glitch3_q", qEver, 0);
        checkOutput("glitch3_pulse", pulseEver, 0);
        checkOutput("glitch3_busycnt", busyCount, 3);
        checkOutput("glitch3_busy_end", busy_a, 0);

        // Four-cycle excursion is just long enough to commit, then falls back
        for (int k = 1; k <= 6; k++) begin
            applyStimulus(1'b0, (k <= 4), 1'b0);
            if (k == 5) checkOutput("pulse4_q_e5", q_a, 0);
        end
        checkOutput("pulse4_q_e6", q_a, 1);
        checkOutput("pulse4_pulse_e6", pulse_a, PEN);
        for (int k = 1; k <= 8; k++) begin
            applyStimulus(1'b0, 1'b0, 1'b0);
        end
        checkOutput("pulse4_fall_q", q_a, 0);

        // Reset while checking with cnt=2, then release with D_IN held high
        for (int k = 1; k <= 4; k++) begin
            applyStimulus(1'b0, 1'b1, 1'b0);
        end
        checkOutput("midrst_busy_before", busy_a, 1);
        #2;
        RESET = 1'b1;
        #1;
        checkOutput("midrst_busy_async", busy_a, 0);
        checkOutput("midrst_q_async", q_a, 0);
        applyStimulus(1'b1, 1'b1, 1'b0);
        riseEdge = 0;
        for (int e = 1; e <= 20 && riseEdge == 0; e++) begin
            applyStimulus(1'b0, 1'b1, 1'b0);
            if (q_a) riseEdge = e;
        end
        checkOutput("midrst_rise_edge", riseEdge, 6);

        // Wide instance: nine-cycle glitch rejected
        busyCount = 0;
        qEver     = 1'b0;
        pulseEver = 1'b0;
        for (int k = 1; k <= 20; k++) begin
            applyStimulus(1'b0, 1'b1, (k <= 9));
            if (busy_b) busyCount++;
            qEver     = qEver | q_b;
            pulseEver = pulseEver | pulse_b;
        end
        checkOutput("wide_glitch9_q", qEver, 0);
        checkOutput("wide_glitch9_pulse", pulseEver, 0);
        checkOutput("wide_glitch9_busycnt", busyCount, 9);

        // Wide instance: held rise commits on edge 13
        riseEdge    = 0;
        pulseAtRise = 1'b0;
        for (int e = 1; e <= 30 && riseEdge == 0; e++) begin
            applyStimulus(1'b0, 1'b1, 1'b1);
            if (q_b) begin
                riseEdge    = e;
                pulseAtRise = pulse_b;
            end
        end
        checkOutput("wide_rise_edge", riseEdge, 13);
        checkOutput("wide_rise_pulse", pulseAtRise, PEN);
        applyStimulus(1'b0, 1'b1, 1'b1);
        checkOutput("wide_pulse_clear", pulse_b, 0);
        checkOutput("wide_q_hold", q_b, 1);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
